// File: rtl/tx_scheduler.sv
// Round-robin owner of the shared serial transmitter: arbitrates requesters,
// pulses tx_start with the latched byte, waits for tx_done or the watchdog, then acks.
module tx_scheduler #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [8*N-1:0]   req_data,
    input  logic             tx_done,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     ack,
    output logic             timeout_err,
    output logic             busy,
    output logic [1:0]       state_dbg_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // Handshake: requester i holds req[i] with its byte until ack[i] pulses;
    // tx_start is a one-cycle pulse, tx_done a one-cycle pulse back.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            terr_q, terr_d;
    logic            busy_q, busy_d;

    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    req_rot;
    logic [PW-1:0]   win_off;
    logic [PW:0]     win_sum;
    logic [PW-1:0]   win_idx;
    logic [7:0]      win_byte;
    logic [PW-1:0]   ptr_next;

    // Rotate so bit j is requester (ptr+j) mod N; lowest set bit wins.
    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> ptr_q);

    always_comb begin
        win_off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) win_off = PW'(j);
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= (PW+1)'(N)) win_sum = win_sum - (PW+1)'(N);
        win_idx = win_sum[PW-1:0];
    end

    assign win_byte = 8'(req_data >> {win_idx, 3'b000});
    assign ptr_next = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        wcnt_d     = wcnt_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        ack_d      = ack_q;
        terr_d     = terr_q;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d    = S_START;
                    owner_d    = win_idx;
                    grant_d    = N'(1) << win_idx;
                    tx_data_d  = win_byte;
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_START: begin
                tx_start_d = 1'b0;
                wcnt_d     = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + CW'(1);
                // A completion on the final watchdog cycle still counts as success.
                if (tx_done) begin
                    state_d = S_ACK;
                    ack_d   = grant_q;
                    grant_d = '0;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_ACK;
                    ack_d   = grant_q;
                    grant_d = '0;
                    terr_d  = 1'b1;
                end
            end
            S_ACK: begin
                ack_d   = '0;
                terr_d  = 1'b0;
                busy_d  = 1'b0;
                ptr_d   = ptr_next;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            wcnt_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            terr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            wcnt_q     <= wcnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            terr_q     <= terr_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant       = grant_q;
    assign ack         = ack_q;
    assign timeout_err = terr_q;
    assign busy        = busy_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: directed scenarios plus random transfers checked
// against a transaction-level round-robin model.
module tb_tx_scheduler;

    localparam int N  = 4;
    localparam int TO = 8;
    localparam int CW = 4;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic           tx_done;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           timeout_err;
    logic           busy;
    logic [1:0]     state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int model_ptr = 0;

    tx_scheduler #(.N(N), .TIMEOUT(TO), .CW(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .tx_done     (tx_done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .grant       (grant),
        .ack         (ack),
        .timeout_err (timeout_err),
        .busy        (busy),
        .state_dbg_o (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Round-robin reference: first requester found walking from the pointer.
    function automatic int model_winner(input logic [N-1:0] rv, input int p);
        for (int k = 0; k < N; k++) begin
            if (((rv >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_start"}, 32'(tx_start), 0);
        check_eq({tag, "_data"},  32'(tx_data), 0);
        check_eq({tag, "_grant"}, 32'(grant), 0);
        check_eq({tag, "_ack"},   32'(ack), 0);
        check_eq({tag, "_err"},   32'(timeout_err), 0);
        check_eq({tag, "_busy"},  32'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        check_all_zero("rst");
        #1 reset = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("idle_noreq_grant", 32'(grant), 0);
            check_eq("idle_noreq_busy", 32'(busy), 0);
        end
    endtask

    // Called while the DUT sits in IDLE; d = WAIT cycle index carrying tx_done (>= TO: never).
    task automatic run_transfer(input logic [N-1:0] rv, input logic [8*N-1:0] dv,
                                input int d, input bit start_done);
        int w, c;
        logic [N-1:0] eg;
        logic [7:0] eb;
        bit exp_err;
        w  = model_winner(rv, model_ptr);
        eg = N'(1 << w);
        eb = 8'(dv >> (8 * w));
        req = rv; req_data = dv;
        @(posedge clock); #1;
        req      = ($urandom_range(0, 1) == 1) ? '0 : N'($urandom);
        req_data = $urandom;
        tx_done  = start_done;
        @(negedge clock);
        check_eq("start_pulse", 32'(tx_start), 1);
        check_eq("start_grant", 32'(grant), 32'(eg));
        check_eq("start_data", 32'(tx_data), 32'(eb));
        check_eq("start_busy", 32'(busy), 1);
        @(posedge clock); #1;
        c = 0;
        forever begin
            tx_done = (c == d);
            @(negedge clock);
            check_eq("wait_grant", 32'(grant), 32'(eg));
            check_eq("wait_start", 32'(tx_start), 0);
            check_eq("wait_ack", 32'(ack), 0);
            check_eq("wait_data", 32'(tx_data), 32'(eb));
            if (c == d || c == TO - 1) break;
            @(posedge clock); #1;
            c++;
        end
        exp_err = (c != d);
        @(posedge clock); #1;
        tx_done = 1'b0; req = '0;
        @(negedge clock);
        check_eq("ack_vec", 32'(ack), 32'(eg));
        check_eq("ack_err", 32'(timeout_err), 32'(exp_err));
        check_eq("ack_grant", 32'(grant), 0);
        check_eq("ack_busy", 32'(busy), 1);
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("idle_ack", 32'(ack), 0);
        check_eq("idle_err", 32'(timeout_err), 0);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_start", 32'(tx_start), 0);
        check_eq("idle_data", 32'(tx_data), 32'(eb));
        model_ptr = (w + 1) % N;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check_eq("grant_onehot", 32'($onehot0(grant)), 1);
            check_eq("ack_onehot", 32'($onehot0(ack)), 1);
            check_eq("grant_ack_excl", 32'((|grant) && (|ack)), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [N-1:0] rv;
        reset = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
        #1;
        check_all_zero("por");
        do_reset();

        // Single request, done 5 cycles after tx_start.
        run_transfer(4'b0100, 32'h00A5_0000, 4, 1'b0);
        // Pointer now past requester 2: 0 before 2.
        run_transfer(4'b0101, 32'h0000_0000 | $urandom, 1, 1'b0);
        run_transfer(4'b0101, $urandom, 0, 1'b1);

        do_reset();
        for (int i = 0; i < 5; i++) run_transfer(4'b1111, 32'h4433_2211, 2, 1'b0);

        // Watchdog abort, collision on the last watchdog cycle, done just before it.
        run_transfer(4'b0001, $urandom, TO + 5, 1'b0);
        run_transfer(4'b0001, $urandom, TO - 1, 1'b0);
        run_transfer(4'b0010, $urandom, TO - 2, 1'b0);

        // Reset in the middle of WAIT.
        req = 4'b0010; req_data = $urandom;
        @(posedge clock); #1; req = '0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("midrst_grant", 32'(grant), 32'(4'b0010));
        #2 reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clock);
        check_eq("midrst_hold_ack", 32'(ack), 0);
        #1 reset = 1'b0;
        model_ptr = 0;
        run_transfer(4'b1111, $urandom, 1, 1'b0);
        run_transfer(4'b0010, $urandom, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rv = N'($urandom_range(1, (1 << N) - 1));
            run_transfer(rv, $urandom, $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Round-robin controller that shares one downstream serial transmitter among N requesters. It accepts level requests with a byte each, grants one requester at a time, issues a single-cycle start pulse with the latched byte, and waits for the transmitter's completion. It then acknowledges the requester and moves on, with a watchdog that aborts a transfer whose completion never arrives. It sits between the lab4 client logic and the transmit-pulse/shift stage, and is the only block allowed to drive that stage's start input.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- TIMEOUT, 1024, WAIT-state cycles before abort (≥2)
- CW, 11, watchdog counter width; must satisfy 2^CW > TIMEOUT

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clock is clock
- req  in  N  level request per requester; bit i = requester i
- req_data  in  8N  byte for requester i on bits [8i+7:8i]
- tx_done  in  1  single-cycle completion pulse from transmitter
- tx_start  out  1  single-cycle start pulse to transmitter
- tx_data  out  8  byte for current transfer, stable from tx_start until ack
- grant  out  N  one-hot owner of current transfer, 0 when idle
- ack  out  N  single-cycle completion pulse to the owner
- timeout_err  out  1  single-cycle pulse, coincident with ack on abort
- busy  out  1  high in every state except IDLE

## Operation
- Reset (async): state=IDLE, ptr=0, wcnt=0; tx_start=0, tx_data=0, grant=0, ack=0, timeout_err=0, busy=0.
- States: IDLE, START, WAIT, ACK. All outputs are registered.
- IDLE: if |req, choose winner w = first set bit searching ptr, ptr+1, …, ptr+N-1 (mod N). Next edge: state←START, grant←onehot(w), tx_data←req_data[w], tx_start←1, busy←1. If req==0, remain in IDLE.
- START: lasts exactly one cycle. Next edge: tx_start←0, wcnt←0, state←WAIT. tx_done is ignored in START.
- WAIT: each edge, wcnt←wcnt+1.
  - If tx_done=1: state←ACK, ack←grant, grant←0.
  - Else if wcnt==TIMEOUT-1: state←ACK, ack←grant, grant←0, timeout_err←1.
  - If tx_done and timeout occur in the same cycle, tx_done wins and timeout_err stays 0.
- ACK: lasts one cycle. Next edge: ack←0, timeout_err←0, busy←0, ptr←(w+1) mod N, state←IDLE.
- req is sampled only in IDLE. Dropping req mid-transfer does not cancel the transfer; that requester still receives ack.
- A requester that keeps req high after its ack is re-arbitrated normally. Round-robin ordering guarantees every other pending requester is served before it is served again.
- req_data is sampled only on the IDLE→START edge; later changes do not affect tx_data.
- tx_data holds its last value after the transfer completes; it is not cleared.
- Reset asserted mid-transfer aborts immediately, with no ack and no error pulse.

## Timing
- Arbitration latency: req seen high in IDLE at edge k → grant/tx_start/tx_data valid after edge k.
- tx_start is high for exactly one cycle, the same cycle grant first rises.
- tx_done arriving in the first WAIT cycle produces ack after the following edge. The minimum transfer is 4 cycles (IDLE→START→WAIT→ACK→IDLE).
- Abort occurs TIMEOUT cycles after entering WAIT with no tx_done.
- Back-to-back: the earliest next tx_start is 2 cycles after ack rises (ACK, then IDLE).
- grant and ack are never both nonzero in the same cycle. At most one bit of grant and at most one bit of ack is set at any time.

## Test plan
- Single request: reset, req=4'b0100, req_data byte2=8'hA5, tx_done pulsed 5 cycles after tx_start → tx_start 1 cycle with tx_data=A5, grant=0100, then ack=0100 for 1 cycle, timeout_err=0, busy falls after ACK.
- Round robin: req=4'b1111 held, bytes 11/22/33/44, tx_done after 3 WAIT cycles each → tx_data sequence 11,22,33,44,11, with acks 0001,0010,0100,1000,0001.
- Fairness from pointer: after serving requester 2, req=4'b0101 → requester 0 is skipped in favour of requester 2? No: ptr=3, so the search yields 0 first; expect grant=0001, then grant=0100.
- Timeout: TIMEOUT=8, req=0001, tx_done never asserted → ack=0001 and timeout_err=1 in the same cycle, exactly 8 cycles after WAIT entry; then IDLE with ptr=1.
- Done/timeout collision: tx_done asserted exactly on the wcnt==TIMEOUT-1 cycle → ack with timeout_err=0.
- Reset mid-WAIT: assert reset with grant=0010 → all outputs 0 immediately, no ack; after release, req=0010 is served again starting from ptr=0.
